// File: rtl/fifo_flags_pkg.sv
// rtl/fifo_flags_pkg.sv - shared widths and destination field position for the FIFO, arbiter and demux
package fifo_flags_pkg;

  localparam int DATA_WIDTH = 6;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  // Destination lives in the top two data bits so arbiter and demux slice the same field.
  localparam int DEST_MSB = DATA_WIDTH - 1;
  localparam int DEST_LSB = DATA_WIDTH - 2;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  function automatic logic [1:0] dest_of(input word_t w);
    return w[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/fifo_flags_if.sv
// rtl/fifo_flags_if.sv - push/pop, data, threshold and status bundle of one FIFO
interface fifo_flags_if;
  import fifo_flags_pkg::*;

  logic  push;
  word_t data_in;
  logic  pop;
  word_t data_out;
  logic  valid_out;
  logic  empty;
  logic  full;
  logic  almost_full;
  logic  almost_empty;
  cnt_t  umbral_af;
  cnt_t  umbral_ae;
  logic  error;
  cnt_t  count;

  modport master (
    output push, data_in, pop, umbral_af, umbral_ae,
    input  data_out, valid_out, empty, full, almost_full, almost_empty, error, count
  );

  modport slave (
    input  push, data_in, pop, umbral_af, umbral_ae,
    output data_out, valid_out, empty, full, almost_full, almost_empty, error, count
  );

endinterface

// File: rtl/fifo_flags_memoria_dp.sv
// rtl/fifo_flags_memoria_dp.sv - DEPTH x DATA_WIDTH register array, synchronous write, registered read
module memoria_dp
  import fifo_flags_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we_i,
  input  ptr_t  waddr_i,
  input  word_t wdata_i,
  input  logic  re_i,
  input  ptr_t  raddr_i,
  output word_t rdata_o
);

  word_t mem_q [DEPTH];
  word_t rdata_q;

  // Storage is deliberately left unreset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_flags.sv
// rtl/fifo_flags.sv - single-clock FIFO with registered status flags and sticky error
module fifo_flags
  import fifo_flags_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fifo_flags_if.slave bus
);

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic empty_q, empty_d;
  logic full_q, full_d;
  logic af_q, af_d;
  logic ae_q, ae_d;
  logic valid_q, valid_d;
  logic error_q, error_d;
  logic push_acc, pop_acc;

  always_comb begin
    pop_acc  = bus.pop && !empty_q;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push_acc = bus.push && (!full_q || pop_acc);

    wr_ptr_d = wr_ptr_q + ptr_t'(push_acc);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop_acc);
    count_d  = count_q + cnt_t'(push_acc) - cnt_t'(pop_acc);
    valid_d  = pop_acc;

    // Flags come from the next count so they move on the same edge as count.
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    af_d     = (count_d >= bus.umbral_af);
    ae_d     = (count_d <= bus.umbral_ae);

    error_d  = error_q
             | (bus.push && full_q && !bus.pop)
             | (bus.pop && empty_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  memoria_dp u_mem (
    .clk     (clk),
    .rst     (reset),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .re_i    (pop_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.data_out)
  );

  assign bus.valid_out    = valid_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.error        = error_q;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_flags.sv
// tb/tb_fifo_flags.sv - directed self-checking bench for fifo_flags
module tb_fifo_flags;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fifo_flags_if bus ();

  fifo_flags dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic p, input logic q, input logic [5:0] d);
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.data_in  = '0;
    bus.umbral_af = 4'd6;
    bus.umbral_ae = 4'd1;
    @(posedge clk);
    @(posedge clk);
    #1;

    // 1: reset state
    chk("rst_empty", bus.empty, 1);
    chk("rst_ae", bus.almost_empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_dout", bus.data_out, 0);
    reset = 1'b0;

    // 2: fill with 01..08, almost_full from 6, full at 8
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 6'(i));
      chk("fill_count", bus.count, i);
      chk("fill_af", bus.almost_full, (i >= 6) ? 1 : 0);
      chk("fill_ae", bus.almost_empty, (i <= 1) ? 1 : 0);
      chk("fill_full", bus.full, (i == 8) ? 1 : 0);
    end
    chk("fill_error", bus.error, 0);
    cyc(1'b1, 1'b0, 6'h3f);
    chk("ovf_error", bus.error, 1);
    chk("ovf_count", bus.count, 8);

    // 3: drain in order
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 6'h00);
      chk("drain_dout", bus.data_out, i);
      chk("drain_valid", bus.valid_out, 1);
      chk("drain_count", bus.count, 8 - i);
    end
    chk("drain_empty", bus.empty, 1);
    cyc(1'b0, 1'b1, 6'h00);
    chk("udf_valid", bus.valid_out, 0);
    chk("udf_error", bus.error, 1);
    chk("udf_dout_hold", bus.data_out, 8);
    chk("udf_count", bus.count, 0);

    // 4: full with simultaneous push+pop, plus threshold edge values
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 6'(8'h10 + i));
    chk("f4_full", bus.full, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 6'(8'h18 + i));
      chk("pp_dout", bus.data_out, 8'h10 + i);
      chk("pp_valid", bus.valid_out, 1);
      chk("pp_count", bus.count, 8);
      chk("pp_full", bus.full, 1);
    end
    chk("pp_error", bus.error, 0);
    bus.umbral_af = 4'd9;
    bus.umbral_ae = 4'd8;
    cyc(1'b0, 1'b0, 6'h00);
    chk("af_over_depth", bus.almost_full, 0);
    chk("ae_at_depth", bus.almost_empty, 1);
    chk("idle_valid", bus.valid_out, 0);
    bus.umbral_af = 4'd0;
    bus.umbral_ae = 4'd1;
    cyc(1'b0, 1'b0, 6'h00);
    chk("af_zero", bus.almost_full, 1);
    chk("ae_restored", bus.almost_empty, 0);
    bus.umbral_af = 4'd6;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 6'h00);
      chk("pp_drain", bus.data_out, (i < 4) ? (8'h14 + i) : (8'h18 + i - 4));
    end
    chk("pp_drain_empty", bus.empty, 1);
    chk("pp_drain_error", bus.error, 0);

    // 5: wrap-around across the pointer boundary
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 6'(8'h20 + i));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 6'h00);
      chk("wrap_a", bus.data_out, 8'h20 + i);
    end
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 6'(8'h30 + i));
    chk("wrap_count6", bus.count, 6);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 6'h00);
      chk("wrap_b", bus.data_out, 8'h30 + i);
    end
    chk("wrap_count0", bus.count, 0);
    chk("wrap_empty", bus.empty, 1);
    chk("wrap_error", bus.error, 0);

    // 6: asynchronous reset mid-stream
    do_reset();
    cyc(1'b0, 1'b1, 6'h00);
    chk("r6_udf_error", bus.error, 1);
    cyc(1'b1, 1'b0, 6'h2a);
    cyc(1'b1, 1'b0, 6'h2b);
    cyc(1'b1, 1'b0, 6'h2c);
    cyc(1'b0, 1'b1, 6'h00);
    chk("r6_pre_dout", bus.data_out, 8'h2a);
    bus.push    = 1'b1;
    bus.pop     = 1'b1;
    bus.data_in = 6'h15;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count", bus.count, 0);
    chk("ar_empty", bus.empty, 1);
    chk("ar_ae", bus.almost_empty, 1);
    chk("ar_full", bus.full, 0);
    chk("ar_af", bus.almost_full, 0);
    chk("ar_valid", bus.valid_out, 0);
    chk("ar_error", bus.error, 0);
    chk("ar_dout", bus.data_out, 0);
    #4;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 6'h3e);
    chk("ar_push_count", bus.count, 1);
    cyc(1'b1, 1'b1, 6'h11);
    chk("ar_first_word", bus.data_out, 8'h3e);
    chk("ar_count_hold", bus.count, 1);
    cyc(1'b0, 1'b1, 6'h00);
    chk("ar_second_word", bus.data_out, 8'h11);
    chk("ar_final_empty", bus.empty, 1);
    chk("ar_final_error", bus.error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
Synchronous single-clock FIFO that buffers words ahead of the 4-way priority arbiter. Four instances feed the arbiter; it consumes each one's empty and almost_full flags and drives pop back into it. The same block serves as the per-destination output FIFO behind the arbiter's demux, which drives its push. It provides registered status flags, programmable thresholds and sticky overflow/underflow error reporting.

Parameters:
DATA_WIDTH, 6, word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the 2-bit destination consumed by the arbiter
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH = 8 entries

Ports:
clk  input  1  single clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
push  input  1  write request; data_in is written when the push is accepted
data_in  input  DATA_WIDTH  write data
pop  input  1  read request
data_out  output  DATA_WIDTH  registered read data
valid_out  output  1  data_out holds a freshly popped word in this cycle
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= umbral_af
almost_empty  output  1  count <= umbral_ae
umbral_af  input  ADDR_WIDTH+1  almost-full threshold, sampled every cycle
umbral_ae  input  ADDR_WIDTH+1  almost-empty threshold, sampled every cycle
error  output  1  sticky overflow/underflow indicator
count  output  ADDR_WIDTH+1  current occupancy

Behaviour:
- Reset values (asynchronous assertion):
  - wr_ptr = rd_ptr = 0, count = 0
  - data_out = 0, valid_out = 0, error = 0
  - empty = 1, full = 0, almost_full = 0, almost_empty = 1
  - Memory contents are not reset.
- Accepted push: push && (!full || pop_accepted). The word is written at mem[wr_ptr], and wr_ptr advances with wrap from DEPTH-1 to 0.
- Accepted pop (pop_accepted): pop && !empty. On the next edge, data_out <= mem[rd_ptr], valid_out <= 1, and rd_ptr advances with wrap. Read latency is 1 cycle.
- No accepted pop: valid_out <= 0 and data_out holds its last value.
- Count update: count_next = count + push_acc - pop_acc. Both pointers and count wrap or saturate exactly at DEPTH.
- Status flags: all flags are registered and computed from count_next, so each flag reflects the operation in the same edge that updates count. No combinational path runs from push/pop to any flag.
- Simultaneous push and pop:
  - When full: both are accepted and count stays at DEPTH.
  - When empty: the push is accepted, the pop is rejected (no fall-through) and flagged as underflow.
  - Otherwise: both are accepted.
- Overflow: push && full && !pop sets error and the write is dropped.
- Underflow: pop && empty sets error and state is unchanged.
- error is sticky and cleared only by reset.
- Threshold edge values:
  - umbral_af = 0 forces almost_full = 1.
  - umbral_af > DEPTH keeps almost_full = 0.
  - umbral_ae >= DEPTH keeps almost_empty = 1.
- Reset asserted mid-operation: all state clears asynchronously. In-flight pushes and pops in that cycle are discarded.
- Flag timing toward the arbiter: the arbiter registers empty/almost_full one cycle later. It may therefore pop one extra cycle on the last word; that pop is rejected safely and sets error. The bench checks error only on scenarios where this race cannot occur.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults and the destination field position (DEST_MSB = DATA_WIDTH-1, DEST_LSB = DATA_WIDTH-2), so the arbiter and demux agree with this block.
- One sub-module: memoria_dp, a DEPTH x DATA_WIDTH dual-port register array with one synchronous write port and one registered read port.
- Pointer, count and flag logic stay in fifo_flags.

Test Plan:
1. Reset with push = pop = 0 -> empty = 1, almost_empty = 1, full = 0, count = 0, valid_out = 0, error = 0.
2. Write 8 words 6'h01..6'h08 with umbral_af = 6 -> almost_full rises at count 6, full = 1 after the 8th push, error stays 0. A 9th push -> error = 1 and count stays 8.
3. From full, pop 8 times -> data_out = 6'h01..6'h08 in order, valid_out high 1 cycle after each pop, empty = 1 after the last pop. A 9th pop -> error stays set and valid_out = 0.
4. Fill to 8, then push+pop in the same cycle for 4 cycles -> count stays 8, full stays 1, data_out follows FIFO order, error = 0.
5. Wrap-around: push 5, pop 5, push 6, pop 6 -> output order is preserved across the pointer wrap and count returns to 0.
6. Push 3 words, assert reset for half a cycle mid-stream -> all outputs are at reset values before the next edge, and the subsequent push/pop restarts at address 0.
